// File: rtl/clb_cfg_pkg.sv
// Shared types and size helpers for the CLB tile configuration loader.
package clb_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2,
        ERR    = 2'd3
    } cfg_state_t;

    // Number of stream beats needed to carry one full context.
    function automatic int nbeats(input int conf_w, input int sw);
        return (conf_w + sw - 1) / sw;
    endfunction

    // Context index width; never narrower than one bit.
    function automatic int ctxw(input int nctx);
        return (nctx < 2) ? 1 : $clog2(nctx);
    endfunction

endpackage

// File: rtl/clb_tile_config_if.sv
// Configuration beat stream: valid/ready handshake with a last-beat marker.
interface clb_tile_config_if #(
    parameter int SW = 8
);
    logic          cfg_valid;
    logic [SW-1:0] cfg_data;
    logic          cfg_last;
    logic          cfg_ready;

    modport master (
        output cfg_valid,
        output cfg_data,
        output cfg_last,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_data,
        input  cfg_last,
        output cfg_ready
    );
endinterface

// File: rtl/clb_cfg_ctx_store.sv
// Context storage, active-context selection and registered configuration output.
module clb_cfg_ctx_store
    import clb_cfg_pkg::*;
#(
    parameter int CONF_W = 256,
    parameter int NCTX   = 4,
    parameter int CTXW   = ctxw(NCTX)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [CTXW-1:0]   i_wr_ctx,
    input  logic [CONF_W-1:0] i_wr_data,
    input  logic              i_act_switch,
    input  logic [CTXW-1:0]   i_act_ctx,
    input  logic              i_lock,
    input  logic [CTXW-1:0]   i_lock_ctx,
    output logic              o_switch_err,
    output logic [CTXW-1:0]   o_cur_ctx,
    output logic [CONF_W-1:0] o_conf_out,
    output logic              o_cset
);

    logic [CONF_W-1:0] r_mem [NCTX];
    logic [CTXW-1:0]   r_cur;
    logic [CONF_W-1:0] r_conf;
    logic              r_switch_err;
    logic              r_changed;
    logic              r_cset;

    logic              w_out_range;
    logic              w_refuse;
    logic              w_accept;
    logic              w_wr_ok;
    logic [CTXW-1:0]   w_next_cur;
    logic [CONF_W-1:0] w_next_conf;

    // Index codes beyond NCTX only exist when NCTX is not a power of two.
    generate
        if (NCTX < (1 << CTXW)) begin : g_range_chk
            assign w_out_range = (int'(i_act_ctx) >= NCTX);
        end else begin : g_no_range_chk
            assign w_out_range = 1'b0;
        end
    endgenerate

    assign w_wr_ok  = i_wr_en && (int'(i_wr_ctx) < NCTX);
    assign w_refuse = i_act_switch && (w_out_range || (i_lock && (i_act_ctx == i_lock_ctx)));
    assign w_accept = i_act_switch && !w_refuse;

    // Look ahead to the context that will be active after this edge; a commit
    // landing in that same context bypasses the storage so conf_out is fresh.
    always_comb begin
        w_next_cur  = r_cur;
        w_next_conf = r_conf;
        if (w_accept) begin
            w_next_cur = i_act_ctx;
        end
        if (w_wr_ok && (i_wr_ctx == w_next_cur)) begin
            w_next_conf = i_wr_data;
        end else begin
            w_next_conf = r_mem[w_next_cur];
        end
    end

    // Context storage write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NCTX; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_mem[i_wr_ctx] <= i_wr_data;
        end
    end

    // Active context, registered output vector and status pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cur        <= '0;
            r_conf       <= '0;
            r_switch_err <= 1'b0;
            r_changed    <= 1'b0;
            r_cset       <= 1'b0;
        end else begin
            r_cur        <= w_next_cur;
            r_conf       <= w_next_conf;
            r_switch_err <= w_refuse;
            r_changed    <= (w_next_conf != r_conf);
            r_cset       <= r_changed;
        end
    end

    assign o_switch_err = r_switch_err;
    assign o_cur_ctx    = r_cur;
    assign o_conf_out   = r_conf;
    assign o_cset       = r_cset;

endmodule

// File: rtl/clb_tile_config.sv
// Multi-context configuration loader for one CLB tile: frame assembly FSM
// feeding a context store that drives the active configuration vector.
module clb_tile_config
    import clb_cfg_pkg::*;
#(
    parameter int CONF_W = 256,
    parameter int SW     = 8,
    parameter int NCTX   = 4,
    parameter int CTXW   = ctxw(NCTX)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [CTXW-1:0]   load_ctx,
    input  logic              load_abort,
    clb_tile_config_if.slave  cfg,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_err,
    input  logic              act_switch,
    input  logic [CTXW-1:0]   act_ctx,
    output logic              switch_err,
    output logic [CTXW-1:0]   cur_ctx,
    output logic [CONF_W-1:0] conf_out,
    output logic              cset
);

    localparam int NBEATS = nbeats(CONF_W, SW);
    localparam int BCW    = $clog2(NBEATS + 1);
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(NBEATS - 1);

    cfg_state_t        r_state;
    cfg_state_t        w_next_state;
    logic [BCW-1:0]    r_beat_cnt;
    logic [CTXW-1:0]   r_load_ctx;
    logic [CONF_W-1:0] r_shadow;

    logic w_ready;
    logic w_busy;
    logic w_done;
    logic w_err;
    logic w_wr_en;
    logic w_lock;
    logic w_beat;

    assign w_beat = cfg.cfg_valid && w_ready;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and state-derived outputs; abort beats any beat.
    always_comb begin
        w_next_state = r_state;
        w_ready      = 1'b0;
        w_busy       = 1'b1;
        w_done       = 1'b0;
        w_err        = 1'b0;
        w_wr_en      = 1'b0;
        w_lock       = 1'b0;
        case (r_state)
            IDLE: begin
                w_busy = 1'b0;
                if (load_start) begin
                    w_next_state = LOAD;
                end
            end
            LOAD: begin
                w_ready = 1'b1;
                w_lock  = 1'b1;
                if (load_abort) begin
                    w_next_state = IDLE;
                end else if (cfg.cfg_valid) begin
                    if (r_beat_cnt == LAST_BEAT) begin
                        w_next_state = cfg.cfg_last ? COMMIT : ERR;
                    end else if (cfg.cfg_last) begin
                        w_next_state = ERR;
                    end
                end
            end
            COMMIT: begin
                w_done       = 1'b1;
                w_wr_en      = 1'b1;
                w_next_state = IDLE;
            end
            ERR: begin
                w_err        = 1'b1;
                w_lock       = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Frame assembly: latch target, count beats, place each beat LSB-first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_beat_cnt <= '0;
            r_load_ctx <= '0;
            r_shadow   <= '0;
        end else if ((r_state == IDLE) && load_start) begin
            r_beat_cnt <= '0;
            r_load_ctx <= load_ctx;
            r_shadow   <= '0;
        end else if ((r_state == LOAD) && !load_abort && w_beat) begin
            for (int i = 0; i < CONF_W; i++) begin
                if (r_beat_cnt == BCW'(i / SW)) begin
                    r_shadow[i] <= cfg.cfg_data[i % SW];
                end
            end
            if (r_beat_cnt != LAST_BEAT) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
        end
    end

    assign cfg.cfg_ready = w_ready;
    assign load_busy     = w_busy;
    assign load_done     = w_done;
    assign load_err      = w_err;

    clb_cfg_ctx_store #(
        .CONF_W (CONF_W),
        .NCTX   (NCTX),
        .CTXW   (CTXW)
    ) u_store (
        .clk          (clk),
        .rst          (rst),
        .i_wr_en      (w_wr_en),
        .i_wr_ctx     (r_load_ctx),
        .i_wr_data    (r_shadow),
        .i_act_switch (act_switch),
        .i_act_ctx    (act_ctx),
        .i_lock       (w_lock),
        .i_lock_ctx   (r_load_ctx),
        .o_switch_err (switch_err),
        .o_cur_ctx    (cur_ctx),
        .o_conf_out   (conf_out),
        .o_cset       (cset)
    );

endmodule

// File: tb/tb_clb_tile_config.sv
// Self-checking bench for clb_tile_config with a small context-level model.
module tb_clb_tile_config;
    import clb_cfg_pkg::*;

    localparam int CONF_W = 20;
    localparam int SW     = 8;
    localparam int NCTX   = 2;
    localparam int CTXW   = 1;

    logic              clk;
    logic              rst;
    logic              load_start;
    logic [CTXW-1:0]   load_ctx;
    logic              load_abort;
    logic              load_busy;
    logic              load_done;
    logic              load_err;
    logic              act_switch;
    logic [CTXW-1:0]   act_ctx;
    logic              switch_err;
    logic [CTXW-1:0]   cur_ctx;
    logic [CONF_W-1:0] conf_out;
    logic              cset;

    clb_tile_config_if #(.SW(SW)) cfgIf ();

    clb_tile_config #(
        .CONF_W (CONF_W),
        .SW     (SW),
        .NCTX   (NCTX),
        .CTXW   (CTXW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .load_ctx   (load_ctx),
        .load_abort (load_abort),
        .cfg        (cfgIf.slave),
        .load_busy  (load_busy),
        .load_done  (load_done),
        .load_err   (load_err),
        .act_switch (act_switch),
        .act_ctx    (act_ctx),
        .switch_err (switch_err),
        .cur_ctx    (cur_ctx),
        .conf_out   (conf_out),
        .cset       (cset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checkCnt = 0;
    int passCnt  = 0;

    logic [CONF_W-1:0] modelMem [NCTX];
    int                modelCur;

    int doneSeen  = 0;
    int errSeen   = 0;
    int csetSeen  = 0;
    int swErrSeen = 0;

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            if (load_done)  doneSeen++;
            if (load_err)   errSeen++;
            if (cset)       csetSeen++;
            if (switch_err) swErrSeen++;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CONF_W-1:0] frameValue(input logic [7:0] b0, input logic [7:0] b1,
                                                     input logic [7:0] b2);
        logic [23:0] w;
        w = {b2, b1, b0};
        return w[CONF_W-1:0];
    endfunction

    // 0 = committed, 1 = framing error, 2 = aborted
    function automatic int predictOutcome(input int lastAt, input int abortAt);
        for (int k = 0; k < 3; k++) begin
            if (k == abortAt) return 2;
            if (k == lastAt) return (k == 2) ? 0 : 1;
            if (k == 2) return 1;
        end
        return 1;
    endfunction

    task automatic applyStimulusSwitch(input int ctx);
        act_switch = 1'b1;
        act_ctx    = ctx[CTXW-1:0];
        tick();
        act_switch = 1'b0;
    endtask

    task automatic applyStimulusFrame(input int ctx, input logic [7:0] b0, input logic [7:0] b1,
                                      input logic [7:0] b2, input int lastAt, input int abortAt,
                                      input bit gaps);
        logic [7:0] b [3];
        b[0] = b0;
        b[1] = b1;
        b[2] = b2;
        load_start = 1'b1;
        load_ctx   = ctx[CTXW-1:0];
        tick();
        load_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            if (k == abortAt) begin
                load_abort      = 1'b1;
                cfgIf.cfg_valid = 1'b1;
                cfgIf.cfg_data  = 8'($urandom);
                tick();
                load_abort      = 1'b0;
                cfgIf.cfg_valid = 1'b0;
                break;
            end
            cfgIf.cfg_valid = 1'b1;
            cfgIf.cfg_data  = b[k];
            cfgIf.cfg_last  = (k == lastAt);
            tick();
            cfgIf.cfg_valid = 1'b0;
            cfgIf.cfg_last  = 1'b0;
            if ((k == lastAt) || (k == 2)) break;
        end
        repeat (3) tick();
    endtask

    task automatic test_reset;
        checkCnt++;
        if ({cfgIf.cfg_ready, load_busy} !== 2'b00)
            $display("[TB] FAIL reset_ready_busy: got %b want 00", {cfgIf.cfg_ready, load_busy});
        else passCnt++;
        checkCnt++;
        if ({load_done, load_err, switch_err, cset} !== 4'b0000)
            $display("[TB] FAIL reset_pulses: got %b want 0000", {load_done, load_err, switch_err, cset});
        else passCnt++;
        checkCnt++;
        if (cur_ctx !== 1'b0) $display("[TB] FAIL reset_cur: got %0d want 0", cur_ctx);
        else passCnt++;
        checkCnt++;
        if (conf_out !== '0) $display("[TB] FAIL reset_conf: got %h want 0", conf_out);
        else passCnt++;
    endtask

    task automatic test_load_switch;
        int d0;
        int c0;
        logic [7:0] beats [3];
        beats[0] = 8'h21;
        beats[1] = 8'h43;
        beats[2] = 8'h65;
        d0 = doneSeen;
        c0 = csetSeen;
        load_start = 1'b1;
        load_ctx   = 1'b1;
        tick();
        load_start = 1'b0;
        checkCnt++;
        if ({cfgIf.cfg_ready, load_busy} !== 2'b11)
            $display("[TB] FAIL load_ready_busy: got %b want 11", {cfgIf.cfg_ready, load_busy});
        else passCnt++;
        for (int k = 0; k < 3; k++) begin
            cfgIf.cfg_valid = 1'b1;
            cfgIf.cfg_data  = beats[k];
            cfgIf.cfg_last  = (k == 2);
            tick();
        end
        cfgIf.cfg_valid = 1'b0;
        cfgIf.cfg_last  = 1'b0;
        checkCnt++;
        if (load_done !== 1'b1) $display("[TB] FAIL commit_done: got %b want 1", load_done);
        else passCnt++;
        tick();
        tick();
        modelMem[1] = frameValue(beats[0], beats[1], beats[2]);
        checkCnt++;
        if (conf_out !== modelMem[0])
            $display("[TB] FAIL inactive_commit_conf: got %h want %h", conf_out, modelMem[0]);
        else passCnt++;
        applyStimulusSwitch(1);
        modelCur = 1;
        checkCnt++;
        if (cur_ctx !== 1'b1) $display("[TB] FAIL switch_cur: got %0d want 1", cur_ctx);
        else passCnt++;
        checkCnt++;
        if (conf_out !== 20'h54321) $display("[TB] FAIL switch_conf: got %h want 54321", conf_out);
        else passCnt++;
        tick();
        tick();
        checkCnt++;
        if ((doneSeen - d0) !== 1) $display("[TB] FAIL done_count: got %0d want 1", doneSeen - d0);
        else passCnt++;
        checkCnt++;
        if ((csetSeen - c0) !== 1) $display("[TB] FAIL cset_count: got %0d want 1", csetSeen - c0);
        else passCnt++;
    endtask

    task automatic test_active_reload;
        logic [7:0] beats [3];
        beats[0] = 8'hFF;
        beats[1] = 8'hFF;
        beats[2] = 8'h0F;
        applyStimulusSwitch(0);
        modelCur = 0;
        tick();
        tick();
        load_start = 1'b1;
        load_ctx   = 1'b0;
        tick();
        load_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cfgIf.cfg_valid = 1'b1;
            cfgIf.cfg_data  = beats[k];
            cfgIf.cfg_last  = (k == 2);
            tick();
        end
        cfgIf.cfg_valid = 1'b0;
        cfgIf.cfg_last  = 1'b0;
        checkCnt++;
        if ({load_done, conf_out} !== {1'b1, modelMem[0]})
            $display("[TB] FAIL reload_commit_cycle: got done=%b conf=%h want done=1 conf=%h",
                     load_done, conf_out, modelMem[0]);
        else passCnt++;
        tick();
        modelMem[0] = frameValue(beats[0], beats[1], beats[2]);
        checkCnt++;
        if ({cset, conf_out} !== {1'b0, 20'hFFFFF})
            $display("[TB] FAIL reload_conf_edge: got cset=%b conf=%h want cset=0 conf=fffff", cset, conf_out);
        else passCnt++;
        tick();
        checkCnt++;
        if (cset !== 1'b1) $display("[TB] FAIL reload_cset_late: got %b want 1", cset);
        else passCnt++;
        tick();
        checkCnt++;
        if (cset !== 1'b0) $display("[TB] FAIL reload_cset_width: got %b want 0", cset);
        else passCnt++;
    endtask

    task automatic test_frame_error;
        int e0;
        e0 = errSeen;
        load_start = 1'b1;
        load_ctx   = 1'b1;
        tick();
        load_start = 1'b0;
        cfgIf.cfg_valid = 1'b1;
        cfgIf.cfg_data  = 8'hAA;
        tick();
        cfgIf.cfg_data = 8'hBB;
        cfgIf.cfg_last = 1'b1;
        tick();
        cfgIf.cfg_valid = 1'b0;
        cfgIf.cfg_last  = 1'b0;
        checkCnt++;
        if (load_err !== 1'b1) $display("[TB] FAIL early_last_err: got %b want 1", load_err);
        else passCnt++;
        tick();
        checkCnt++;
        if (load_busy !== 1'b0) $display("[TB] FAIL err_back_idle: got busy=%b want 0", load_busy);
        else passCnt++;
        applyStimulusSwitch(1);
        checkCnt++;
        if (conf_out !== modelMem[1])
            $display("[TB] FAIL err_ctx_kept: got %h want %h", conf_out, modelMem[1]);
        else passCnt++;
        applyStimulusSwitch(0);
        tick();
        checkCnt++;
        if ((errSeen - e0) !== 1) $display("[TB] FAIL err_count: got %0d want 1", errSeen - e0);
        else passCnt++;
        load_start = 1'b1;
        load_ctx   = 1'b1;
        tick();
        load_start = 1'b0;
        checkCnt++;
        if (cfgIf.cfg_ready !== 1'b1) $display("[TB] FAIL restart_after_err: got ready=%b want 1", cfgIf.cfg_ready);
        else passCnt++;
        load_abort = 1'b1;
        tick();
        load_abort = 1'b0;
        tick();
    endtask

    task automatic test_switch_during_load;
        logic [7:0] beats [3];
        beats[0] = 8'h11;
        beats[1] = 8'h22;
        beats[2] = 8'h03;
        load_start = 1'b1;
        load_ctx   = 1'b1;
        tick();
        load_start = 1'b0;
        cfgIf.cfg_valid = 1'b1;
        cfgIf.cfg_data  = beats[0];
        tick();
        cfgIf.cfg_valid = 1'b0;
        applyStimulusSwitch(1);
        checkCnt++;
        if ({switch_err, cur_ctx} !== {1'b1, 1'b0})
            $display("[TB] FAIL locked_switch: got err=%b cur=%0d want err=1 cur=0", switch_err, cur_ctx);
        else passCnt++;
        applyStimulusSwitch(0);
        checkCnt++;
        if ({switch_err, cur_ctx} !== {1'b0, 1'b0})
            $display("[TB] FAIL free_switch: got err=%b cur=%0d want err=0 cur=0", switch_err, cur_ctx);
        else passCnt++;
        for (int k = 1; k < 3; k++) begin
            cfgIf.cfg_valid = 1'b1;
            cfgIf.cfg_data  = beats[k];
            cfgIf.cfg_last  = (k == 2);
            tick();
        end
        cfgIf.cfg_valid = 1'b0;
        cfgIf.cfg_last  = 1'b0;
        modelMem[1] = frameValue(beats[0], beats[1], beats[2]);
        applyStimulusSwitch(1);
        modelCur = 1;
        checkCnt++;
        if ({switch_err, cur_ctx, conf_out} !== {1'b0, 1'b1, modelMem[1]})
            $display("[TB] FAIL commit_cycle_switch: got err=%b cur=%0d conf=%h want err=0 cur=1 conf=%h",
                     switch_err, cur_ctx, conf_out, modelMem[1]);
        else passCnt++;
        repeat (2) tick();
    endtask

    task automatic test_abort;
        int d0;
        d0 = doneSeen;
        applyStimulusFrame(1, 8'h99, 8'h88, 8'h07, 2, 1, 1'b0);
        checkCnt++;
        if ((doneSeen - d0) !== 0) $display("[TB] FAIL abort_no_done: got %0d want 0", doneSeen - d0);
        else passCnt++;
        checkCnt++;
        if ({load_busy, conf_out} !== {1'b0, modelMem[1]})
            $display("[TB] FAIL abort_ctx_kept: got busy=%b conf=%h want busy=0 conf=%h",
                     load_busy, conf_out, modelMem[1]);
        else passCnt++;
    endtask

    task automatic test_random;
        int d0, e0, c0, s0;
        int expDone, expErr, expCset;
        int ctx, lastAt, abortAt, mode, outcome, nc;
        logic [7:0] b0, b1, b2;
        logic [CONF_W-1:0] nv;
        for (int it = 0; it < 24; it++) begin
            d0 = doneSeen; e0 = errSeen; c0 = csetSeen; s0 = swErrSeen;
            expDone = 0; expErr = 0; expCset = 0;
            ctx  = $urandom_range(0, NCTX - 1);
            b0   = 8'($urandom);
            b1   = 8'($urandom);
            b2   = 8'($urandom);
            mode = $urandom_range(0, 3);
            lastAt  = 2;
            abortAt = -1;
            if (mode == 2) lastAt = $urandom_range(0, 2) - 1;
            if (mode == 3) abortAt = $urandom_range(0, 2);
            outcome = predictOutcome(lastAt, abortAt);
            applyStimulusFrame(ctx, b0, b1, b2, lastAt, abortAt, 1'b1);
            if (outcome == 0) begin
                nv = frameValue(b0, b1, b2);
                expDone = 1;
                if ((ctx == modelCur) && (nv != modelMem[ctx])) expCset++;
                modelMem[ctx] = nv;
            end else if (outcome == 1) begin
                expErr = 1;
            end
            nc = $urandom_range(0, NCTX - 1);
            if (modelMem[nc] != modelMem[modelCur]) expCset++;
            applyStimulusSwitch(nc);
            modelCur = nc;
            repeat (2) tick();
            checkCnt++;
            if ({cur_ctx, conf_out} !== {nc[CTXW-1:0], modelMem[modelCur]})
                $display("[TB] FAIL rand_state it=%0d: got cur=%0d conf=%h want cur=%0d conf=%h",
                         it, cur_ctx, conf_out, nc, modelMem[modelCur]);
            else passCnt++;
            checkCnt++;
            if ({doneSeen - d0, errSeen - e0, csetSeen - c0, swErrSeen - s0} !== {expDone, expErr, expCset, 0})
                $display("[TB] FAIL rand_pulses it=%0d: got done=%0d err=%0d cset=%0d swerr=%0d want %0d %0d %0d 0",
                         it, doneSeen - d0, errSeen - e0, csetSeen - c0, swErrSeen - s0, expDone, expErr, expCset);
            else passCnt++;
        end
    endtask

    task automatic test_reset_midload;
        int d0, e0, c0, s0;
        load_start = 1'b1;
        load_ctx   = 1'b1;
        tick();
        load_start      = 1'b0;
        cfgIf.cfg_valid = 1'b1;
        cfgIf.cfg_data  = 8'h5A;
        tick();
        #2;
        rst = 1'b0;
        #1;
        for (int i = 0; i < NCTX; i++) modelMem[i] = '0;
        modelCur = 0;
        checkCnt++;
        if ({cfgIf.cfg_ready, cur_ctx, conf_out} !== {1'b0, 1'b0, 20'h0})
            $display("[TB] FAIL async_reset: got ready=%b cur=%0d conf=%h want 0 0 0",
                     cfgIf.cfg_ready, cur_ctx, conf_out);
        else passCnt++;
        @(negedge clk);
        rst = 1'b1;
        d0 = doneSeen; e0 = errSeen; c0 = csetSeen; s0 = swErrSeen;
        repeat (5) tick();
        cfgIf.cfg_valid = 1'b0;
        checkCnt++;
        if ({doneSeen - d0, errSeen - e0, csetSeen - c0, swErrSeen - s0, load_busy} !== {0, 0, 0, 0, 1'b0})
            $display("[TB] FAIL post_reset_quiet: got done=%0d err=%0d cset=%0d swerr=%0d busy=%b want all 0",
                     doneSeen - d0, errSeen - e0, csetSeen - c0, swErrSeen - s0, load_busy);
        else passCnt++;
        applyStimulusSwitch(1);
        checkCnt++;
        if (conf_out !== modelMem[1]) $display("[TB] FAIL reset_cleared_ctx1: got %h want 0", conf_out);
        else passCnt++;
    endtask

    initial begin
        rst             = 1'b0;
        load_start      = 1'b0;
        load_ctx        = '0;
        load_abort      = 1'b0;
        act_switch      = 1'b0;
        act_ctx         = '0;
        cfgIf.cfg_valid = 1'b0;
        cfgIf.cfg_data  = '0;
        cfgIf.cfg_last  = 1'b0;
        for (int i = 0; i < NCTX; i++) modelMem[i] = '0;
        modelCur = 0;
        #12;
        test_reset();
        @(negedge clk);
        rst = 1'b1;
        tick();
        test_load_switch();
        test_active_reload();
        test_frame_error();
        test_switch_during_load();
        test_abort();
        test_random();
        test_reset_midload();
        $display("[TB] %0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
